hasti_sram_slave: RTL

HASTI_SRAM_SLAVE -- requirements
Module: hasti_sram_slave

---
 rtl/hasti_sram_slave.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/hasti_sram_slave.sv
// HASTI (AHB-Lite) slave fronting a single-port synchronous SRAM with one-cycle read latency.
// Define HASTI_SRAM_ERR_EN to answer out-of-range or misaligned transfers with a two-cycle ERROR.
//   state  | meaning
//   IDLE   | no data phase pending
//   READ   | read data phase, hrdata = sram_q
//   WRITE  | write data phase, SRAM strobed with hwdata
//   STALL  | read arrived during WRITE; one wait state while the SRAM is re-addressed
//   ERR1   | first ERROR cycle (hreadyout=0, hresp=1)
//   ERR2   | second ERROR cycle (hreadyout=1, hresp=1)
module hasti_sram_slave #(
    parameter int sram_addr_width = 10
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [31:0]                haddr,
    input  logic                       hwrite,
    input  logic [2:0]                 hsize,
    input  logic [2:0]                 hburst,
    input  logic [3:0]                 hprot,
    input  logic [1:0]                 htrans,
    input  logic                       hmastlock,
    input  logic [31:0]                hwdata,
    output logic [31:0]                hrdata,
    input  logic                       hsel,
    input  logic                       hready,
    output logic                       hreadyout,
    output logic                       hresp,
    output logic                       sram_clock,
    output logic [sram_addr_width-1:0] sram_address,
    output logic [3:0]                 sram_byteena,
    output logic [31:0]                sram_data,
    output logic                       sram_wren,
    input  logic [31:0]                sram_q
);

    localparam int AW = sram_addr_width;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_STALL
`ifdef HASTI_SRAM_ERR_EN
        ,
        S_ERR1,
        S_ERR2
`endif
    } state_t;

    state_t        state_q, state_d;
    logic          write_q, write_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [3:0]    byteena_q, byteena_d;

    logic          accept;
    logic          hold_phase;
    logic [AW-1:0] haddr_word;
    logic [3:0]    byteena_new;

    assign sram_clock = clk;
    assign haddr_word = haddr[AW+1:2];

    // STALL and ERR1 advance unconditionally, so nothing is accepted while we hold hreadyout low.
    always_comb begin
        hold_phase = 1'b0;
        case (state_q)
            S_STALL: hold_phase = 1'b1;
`ifdef HASTI_SRAM_ERR_EN
            S_ERR1:  hold_phase = 1'b1;
`endif
            default: hold_phase = 1'b0;
        endcase
    end

    assign accept = hsel && hready && htrans[1] && !hold_phase;

    always_comb begin
        byteena_new = 4'b1111;
        case (hsize)
            3'd0:    byteena_new = 4'b0001 << haddr[1:0];
            3'd1:    byteena_new = haddr[1] ? 4'b1100 : 4'b0011;
            default: byteena_new = 4'b1111;
        endcase
    end

`ifdef HASTI_SRAM_ERR_EN
    logic xfer_err;

    always_comb begin
        xfer_err = |haddr[31:AW+2];
        if (hsize == 3'd1 && haddr[0])
            xfer_err = 1'b1;
        if (hsize == 3'd2 && haddr[1:0] != 2'b00)
            xfer_err = 1'b1;
    end
`endif

    always_comb begin
        state_d   = state_q;
        write_d   = write_q;
        addr_d    = addr_q;
        byteena_d = byteena_q;

        if (accept) begin
            write_d   = hwrite;
            addr_d    = haddr_word;
            byteena_d = byteena_new;
`ifdef HASTI_SRAM_ERR_EN
            if (xfer_err) begin
                write_d   = 1'b0;
                byteena_d = 4'b0000;
            end
`endif
        end

        case (state_q)
            S_STALL: state_d = S_READ;
`ifdef HASTI_SRAM_ERR_EN
            S_ERR1:  state_d = S_ERR2;
`endif
            default: begin
                if (!accept)
                    state_d = S_IDLE;
`ifdef HASTI_SRAM_ERR_EN
                else if (xfer_err)
                    state_d = S_ERR1;
`endif
                else if (hwrite)
                    state_d = S_WRITE;
                else if (state_q == S_WRITE)
                    state_d = S_STALL;
                else
                    state_d = S_READ;
            end
        endcase
    end

    // Reads address the SRAM straight from haddr unless the port is busy with a write or a stall.
    always_comb begin
        hreadyout    = 1'b1;
        hresp        = 1'b0;
        hrdata       = 32'h0;
        sram_wren    = 1'b0;
        sram_byteena = 4'b0000;
        sram_address = haddr_word;
        sram_data    = hwdata;

        case (state_q)
            S_READ: hrdata = sram_q;
            S_WRITE: begin
                sram_wren    = write_q;
                sram_byteena = write_q ? byteena_q : 4'b0000;
                sram_address = addr_q;
            end
            S_STALL: begin
                hreadyout    = 1'b0;
                sram_address = addr_q;
            end
`ifdef HASTI_SRAM_ERR_EN
            S_ERR1: begin
                hreadyout = 1'b0;
                hresp     = 1'b1;
            end
            S_ERR2: hresp = 1'b1;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            write_q   <= 1'b0;
            addr_q    <= '0;
            byteena_q <= 4'b0000;
        end else begin
            state_q   <= state_d;
            write_q   <= write_d;
            addr_q    <= addr_d;
            byteena_q <= byteena_d;
        end
    end

    logic unused_inputs;
    assign unused_inputs = ^{hburst, hprot, hmastlock, haddr[31:AW+2]};

endmodule
